// File: rtl/sel_index_encoder_pkg.sv
// Shared select-path constants and types.
// Imported by the encoder and by the lane mux side.
package bitsim_pkg;

  localparam int NUM_LANE = 16;
  localparam int SEL_WIDTH = $clog2(NUM_LANE) + 1;

  // Code NUM_LANE makes the 17-to-1 mux drive zero.
  localparam logic [SEL_WIDTH-1:0] SEL_ZERO =
    SEL_WIDTH'(NUM_LANE);

  typedef enum logic {
    IDLE,
    EMIT
  } sel_enc_state_t;

endpackage

// File: rtl/sel_index_encoder_if.sv
// Mask-in / select-out handshake bundle.
// slave is the encoder, master is its environment.
interface sel_index_encoder_if;
  import bitsim_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_LANE-1:0]  in_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_WIDTH-1:0] out_sel;
  logic                 out_last;
  logic [SEL_WIDTH-1:0] out_count;

  modport master (
    output in_valid,
    output in_mask,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sel,
    input  out_last,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_mask,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sel,
    output out_last,
    output out_count
  );

endinterface

// File: rtl/sel_index_encoder_lsb.sv
// Lowest-set-bit priority encoder for a lane mask.
// An empty mask yields the zero code.
module lowest_set_bit_encoder
  import bitsim_pkg::*;
(
  input  logic [NUM_LANE-1:0]  mask,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any,
  output logic                 one_hot_or_zero
);

  // Scan high to low so the lowest set lane wins.
  always_comb begin
    idx = SEL_ZERO;
    for (int i = NUM_LANE - 1; i >= 0; i--) begin
      if (mask[i]) idx = SEL_WIDTH'(i);
    end
  end

  assign any = |mask;

  assign one_hot_or_zero =
    ((mask & (mask - NUM_LANE'(1))) == '0);

endmodule

// File: rtl/sel_index_encoder.sv
// Turns a lane mask into ascending select codes,
// one per output handshake, for the lane mux array.
module sel_index_encoder
  import bitsim_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  sel_index_encoder_if.slave  bus
);

  sel_enc_state_t       state_q, state_d;
  logic [NUM_LANE-1:0]  rem_q, rem_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 last_q, last_d;
  logic [SEL_WIDTH-1:0] cnt_q, cnt_d;

  logic                 fire;
  logic                 fire_last;
  logic                 in_rdy;
  logic                 accept;
  logic                 do_step;
  logic                 do_done;
  logic [NUM_LANE-1:0]  enc_mask;
  logic [SEL_WIDTH-1:0] enc_idx;
  logic                 enc_any;
  logic                 enc_one;
  logic [SEL_WIDTH-1:0] pop;

  assign fire = (state_q == EMIT) && bus.out_ready;
  assign fire_last = fire && last_q;

  // Ready is combinational from out_ready so the
  // next mask loads on the last beat with no bubble.
  assign in_rdy = !clear &&
    ((state_q == IDLE) || fire_last);
  assign accept = bus.in_valid && in_rdy;

  assign do_step = fire && !last_q && !clear;
  assign do_done = fire_last && !accept && !clear;

  // One encoder serves both a fresh load and a step.
  assign enc_mask = accept ? bus.in_mask : rem_q;

  lowest_set_bit_encoder u_lsb (
    .mask            (enc_mask),
    .idx             (enc_idx),
    .any             (enc_any),
    .one_hot_or_zero (enc_one)
  );

  // Population count of the incoming mask.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      pop = pop + SEL_WIDTH'(bus.in_mask[i]);
    end
  end

  // Next state and next output registers.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      clear: begin
        state_d = IDLE;
        rem_d   = '0;
        sel_d   = SEL_ZERO;
        last_d  = 1'b0;
        cnt_d   = '0;
      end
      accept: begin
        state_d = EMIT;
        rem_d   = bus.in_mask &
                  (bus.in_mask - NUM_LANE'(1));
        sel_d   = enc_idx;
        last_d  = enc_one;
        cnt_d   = enc_any ? pop : SEL_WIDTH'(1);
      end
      do_step: begin
        rem_d  = rem_q & (rem_q - NUM_LANE'(1));
        sel_d  = enc_idx;
        last_d = enc_one;
      end
      do_done: begin
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= SEL_ZERO;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_sel   = sel_q;
  assign bus.out_last  = last_q;
  assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_sel_index_encoder.sv
// Scoreboard bench for sel_index_encoder.
// Directed boundary runs, then random masks.
module tb_sel_index_encoder;

  logic clk;
  logic rst_n;
  logic clear;

  sel_index_encoder_if bus ();

  sel_index_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sel;
    logic       last;
    logic [4:0] cnt;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  // Reference: every set lane in ascending order,
  // or the lone zero code for an empty mask.
  function automatic void push_mask(logic [15:0] m);
    int lanes[$];
    beat_t b;
    for (int i = 0; i < 16; i++)
      if (m[i]) lanes.push_back(i);
    if (lanes.size() == 0) begin
      b.sel = 5'd16; b.last = 1'b1; b.cnt = 5'd1;
      exp_q.push_back(b);
    end else begin
      foreach (lanes[k]) begin
        b.sel  = 5'(lanes[k]);
        b.last = (k == lanes.size() - 1);
        b.cnt  = 5'(lanes.size());
        exp_q.push_back(b);
      end
    end
  endfunction

  // Input monitor: queue expected codes on accept.
  always @(negedge clk) begin
    if (rst_n && !clear &&
        bus.in_valid && bus.in_ready)
      push_mask(bus.in_mask);
  end

  beat_t held;
  bit    stalled = 0;

  // Output monitor: compare each consumed beat.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n || clear) begin
      exp_q.delete();
      stalled = 0;
    end else if (bus.out_valid) begin
      chk("sel_range", int'(bus.out_sel <= 5'd16), 1);
      if (bus.out_sel == 5'd16)
        chk("zero_last", bus.out_last, 1);
      if (stalled) begin
        chk("hold_sel", bus.out_sel, held.sel);
        chk("hold_last", bus.out_last, held.last);
        chk("hold_cnt", bus.out_count, held.cnt);
      end
      stalled = !bus.out_ready;
      held.sel  = bus.out_sel;
      held.last = bus.out_last;
      held.cnt  = bus.out_count;
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus.out_sel, 99);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sel", bus.out_sel, e.sel);
          chk("sb_last", bus.out_last, e.last);
          chk("sb_count", bus.out_count, e.cnt);
        end
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] m,
                      input bit keep);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !clear) break;
      n++;
      if (n > 500) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    step();
    if (!keep) begin
      bus.in_valid = 1'b0;
      bus.in_mask  = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.out_valid) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 0, 1);
        break;
      end
    end
    step();
  endtask

  bit rand_done;

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sel", bus.out_sel, 16);
    chk("rst_last", bus.out_last, 0);
    chk("rst_count", bus.out_count, 0);
    step();

    bus.out_ready = 1'b1;
    send(16'h0000, 0);
    @(negedge clk);
    chk("zero_valid", bus.out_valid, 1);
    @(negedge clk);
    chk("zero_idle", bus.out_valid, 0);
    step();

    send(16'h8421, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("run4_valid", bus.out_valid, 1);
    end
    @(negedge clk);
    chk("run4_idle", bus.out_valid, 0);
    step();

    send(16'h0006, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("stall_sel", bus.out_sel, 2);
    chk("stall_last", bus.out_last, 1);
    step();
    @(negedge clk);
    chk("stall_sel2", bus.out_sel, 2);
    step();
    bus.out_ready = 1'b1;
    wait_idle();

    bus.in_valid = 1'b1;
    bus.in_mask  = 16'h0001;
    @(negedge clk);
    chk("b2b_rdy_idle", bus.in_ready, 1);
    step();
    bus.in_mask = 16'h0300;
    @(negedge clk);
    chk("b2b_sel0", bus.out_sel, 0);
    chk("b2b_rdy_last", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_sel8", bus.out_sel, 8);
    chk("b2b_v8", bus.out_valid, 1);
    @(negedge clk);
    chk("b2b_sel9", bus.out_sel, 9);
    chk("b2b_v9", bus.out_valid, 1);
    wait_idle();

    send(16'hFFFF, 0);
    repeat (3) step();
    clear = 1'b1;
    @(negedge clk);
    chk("clr_rdy", bus.in_ready, 0);
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_valid", bus.out_valid, 0);
    chk("clr_rdy_after", bus.in_ready, 1);
    step();

    send(16'hFFFF, 0);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_valid", bus.out_valid, 0);
    chk("rst2_rdy", bus.in_ready, 1);
    chk("rst2_sel", bus.out_sel, 16);
    chk("rst2_count", bus.out_count, 0);
    step();

    rand_done = 0;
    fork
      begin
        for (int k = 0; k < 1200; k++) begin
          logic [15:0] m;
          case ($urandom_range(0, 5))
            0: m = 16'h0000;
            1: m = 16'(1) << $urandom_range(0, 15);
            2: m = 16'hFFFF;
            default: m = 16'($urandom);
          endcase
          send(m, $urandom_range(0, 1) == 1);
        end
        bus.in_valid = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        bus.out_ready = 1'b1;
      end
    join

    wait_idle();
    repeat (2) step();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/sel_index_encoder.md
Name: sel_index_encoder

Overview:
- Producer side of the 17-to-1 select path in the bit-serial datapath.
- Accepts a 16-lane nonzero mask and emits, one per output handshake, the 5-bit select code of each set lane in ascending order. The downstream 17-to-1 mux consumes these codes.
- An all-zero mask emits the single "zero" code 16, so the mux drives 0.
- Sits between the activation sparsity detector and the lane mux array.

Parameters:
- NUM_LANE, 16, number of mask lanes; must equal the mux input count.
- SEL_WIDTH, 5, select code width; $clog2(NUM_LANE)+1 so that code NUM_LANE means "zero".

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous abort: drop the current mask and return to IDLE.
- in_valid  input  1  mask valid.
- in_ready  output  1  block can accept a mask this cycle.
- in_mask  input  NUM_LANE  bit i set means lane i is nonzero.
- out_valid  output  1  out_sel is valid.
- out_ready  input  1  consumer accepts out_sel.
- out_sel  output  SEL_WIDTH  lane index 0..15, or 16 for zero.
- out_last  output  1  final code for the current mask.
- out_count  output  SEL_WIDTH  number of codes this mask will emit (1..16), held stable while out_valid.

Behaviour:
- Reset, taken when rst_n=0 at a clk edge:
  - state returns to IDLE.
  - out_valid=0, out_sel=16, out_last=0, out_count=0.
  - Remaining-mask register is cleared.
  - in_ready=1 in the cycle after reset deasserts.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid, latch the mask and move to EMIT.
  - out_sel = index of the lowest set bit, or 16 if the mask is 0.
  - out_last = 1 if the mask has at most one set bit.
  - out_count = popcount, or 1 if the mask is 0.
  - Remaining mask = latched mask with the lowest set bit cleared.
- Latency: out_valid rises 1 cycle after the input handshake.
- EMIT:
  - out_valid=1.
  - The outputs hold steady while out_ready=0 (AXI-style: no retraction, no change).
  - On out_valid && out_ready && !out_last: out_sel takes the lowest set bit of the remaining mask, that bit is cleared, and out_last = (remaining popcount==1). One code per cycle at full throughput.
  - On out_valid && out_ready && out_last:
    - If in_valid is high, the new mask is loaded the same cycle (back-to-back, no bubble); the state stays EMIT.
    - Otherwise the state goes to IDLE and out_valid=0 next cycle.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready and is intentional.
- Code ordering is strictly ascending lane index. Codes are never repeated or skipped.
- Boundary cases:
  - Mask 0xFFFF: 16 codes (0..15), out_last set on code 15, out_count=16.
  - Mask 0x8000: single code 15 with out_last=1.
  - Mask 0x0000: single code 16 with out_last=1 and out_count=1.
- clear:
  - Has priority over any handshake that cycle. Next cycle: IDLE, out_valid=0.
  - in_ready=0 while clear=1, so no mask is accepted.
  - Reset has priority over clear.
- in_mask is sampled only on the input handshake. Changes on in_mask at other times have no effect.
- Assertions for the bench:
  - out_sel <= 16 always.
  - out_sel==16 implies out_last.
  - The outputs are stable under backpressure.

Decomposition:
- Shared package (bitsim_pkg) holds:
  - localparam NUM_LANE=16 and SEL_WIDTH=5.
  - localparam SEL_ZERO = NUM_LANE, shared with the mux side.
  - typedef enum logic {IDLE, EMIT} sel_enc_state_t.
- One sub-module, lowest_set_bit_encoder. It is combinational and takes mask[NUM_LANE-1:0]. It outputs:
  - idx[SEL_WIDTH-1:0], equal to SEL_ZERO when the mask is 0.
  - any.
  - one_hot_or_zero (popcount<=1).
- Popcount for out_count is computed inline.

Test Plan:
- Reset then mask 0x0000, out_ready=1 -> one beat: out_sel=16, out_last=1, out_count=1; IDLE next cycle.
- Mask 0x8421, out_ready=1 -> beats on 4 consecutive cycles: sel=0, 5, 10, 15, with out_last only on 15 and out_count=4 throughout.
- Mask 0x0006 with out_ready toggled 1,0,0,1 -> sel=1 then sel=2. sel=2 with out_last=1 is held for 2 stall cycles, and no code is skipped or duplicated.
- Back-to-back run:
  - Stimulus: mask 0x0001, then mask 0x0300 offered with in_valid held high.
  - Required: sel=0 (last), then 8, then 9 (last) on consecutive cycles.
  - in_ready must be high in the cycle sel=0 is consumed.
- Mask 0xFFFF, clear asserted after the 3rd beat -> beats 0, 1, 2, then out_valid=0 and in_ready=1 the following cycle. Repeat the run with rst_n=0 instead of clear: same result, with out_sel=16 and out_count=0.
- Randomized masks (at least 1000) with random backpressure against a scoreboard:
  - The emitted code set equals the set-bit set, in ascending order.
  - out_last is set exactly once per mask.
  - out_count equals popcount, or 1 if the mask is 0.
